// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback unit.
// The register-file geometry lives here so every writeback block agrees on it.
package wb_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 6;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  typedef enum logic [2:0] {
    SEL_FIFO_FULL,
    SEL_ALU,
    SEL_FIFO,
    SEL_BYPASS,
    SEL_NONE
  } wb_sel_e;

  // x0 and addresses beyond the architectural file never write or touch the scoreboard
  function automatic logic rd_valid(input logic [REG_ADDR_W-1:0] rd);
    return (rd != ZERO_REG) && (int'(rd) < NUM_REGS);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries used to buffer memory-side results.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  wb_entry_t                 push_data,
  input  logic                      pop,
  output wb_entry_t                 head,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers alone decide what is live.
  // A push into a full FIFO is only issued alongside a pop, so the slot is free.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/writeback_unit.sv
// Regfile writer: arbitrates ALU and memory results onto the single write port,
// buffering memory results, and keeps the pending-write scoreboard used by decode.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [REG_ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]            alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [REG_ADDR_W-1:0]        mem_rd,
  input  logic [DATA_W-1:0]            mem_data,
  input  logic                         issue_valid,
  input  logic [REG_ADDR_W-1:0]        issue_rd,
  output logic [NUM_REGS-1:0]          pending,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         write_enable,
  output logic [REG_ADDR_W-1:0]        write_reg,
  output logic [DATA_W-1:0]            write_data
);

  localparam int IDX_W = $clog2(NUM_REGS);

  wb_entry_t alu_entry, mem_entry, fifo_head, out_entry;
  wb_sel_e   sel;
  logic      out_valid;
  logic      fifo_full, fifo_empty, fifo_push, fifo_pop;

  logic                  write_enable_q, write_enable_d;
  logic [REG_ADDR_W-1:0] write_reg_q,    write_reg_d;
  logic [DATA_W-1:0]     write_data_q,   write_data_d;
  logic [NUM_REGS-1:0]   pending_q,      pending_d;

  assign alu_entry = '{rd: alu_rd, data: alu_data};
  assign mem_entry = '{rd: mem_rd, data: mem_data};

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .push_data(mem_entry),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // A full FIFO drains first so memory results cannot be starved by a busy ALU.
  always_comb begin
    sel = SEL_NONE;
    if (fifo_full)        sel = SEL_FIFO_FULL;
    else if (alu_valid)   sel = SEL_ALU;
    else if (!fifo_empty) sel = SEL_FIFO;
    else if (mem_valid)   sel = SEL_BYPASS;
  end

  always_comb begin
    fifo_pop  = reset_n && ((sel == SEL_FIFO_FULL) || (sel == SEL_FIFO));
    alu_ready = reset_n && !fifo_full;
    mem_ready = reset_n && (!fifo_full || fifo_pop);
    fifo_push = mem_valid && mem_ready && (sel != SEL_BYPASS);
    out_valid = (sel != SEL_NONE);
    case (sel)
      SEL_FIFO_FULL, SEL_FIFO: out_entry = fifo_head;
      SEL_ALU:                 out_entry = alu_entry;
      SEL_BYPASS:              out_entry = mem_entry;
      default:                 out_entry = '0;
    endcase
  end

  always_comb begin
    write_enable_d = out_valid && rd_valid(out_entry.rd);
    write_reg_d    = write_reg_q;
    write_data_d   = write_data_q;
    if (write_enable_d) begin
      write_reg_d  = out_entry.rd;
      write_data_d = out_entry.data;
    end
  end

  // Clear for the write leaving this edge, then set for a new issue so set wins.
  always_comb begin
    pending_d = pending_q;
    if (write_enable_q) pending_d[write_reg_q[IDX_W-1:0]] = 1'b0;
    if (issue_valid && rd_valid(issue_rd)) pending_d[issue_rd[IDX_W-1:0]] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      write_enable_q <= 1'b0;
      write_reg_q    <= '0;
      write_data_q   <= '0;
      pending_q      <= '0;
    end else begin
      write_enable_q <= write_enable_d;
      write_reg_q    <= write_reg_d;
      write_data_q   <= write_data_d;
      pending_q      <= pending_d;
    end
  end

  assign write_enable = write_enable_q;
  assign write_reg    = write_reg_q;
  assign write_data   = write_data_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios followed by random traffic, all
// compared against a queue-based reference model of the arbitration rules.
module tb_writeback_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, alu_ready, mem_valid, mem_ready, issue_valid;
  logic [5:0]  alu_rd, mem_rd, issue_rd, write_reg;
  logic [31:0] alu_data, mem_data, write_data, pending;
  logic [1:0]  fifo_count;
  logic        write_enable;

  always #5 clk = ~clk;

  writeback_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .pending     (pending),
    .fifo_count  (fifo_count),
    .write_enable(write_enable),
    .write_reg   (write_reg),
    .write_data  (write_data)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: buffered memory results as {rd,data}, plus output and scoreboard.
  logic [37:0] mq[$];
  logic        m_we = 1'b0;
  logic [5:0]  m_reg = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_pend = '0;
  logic        m_alu_rdy, m_mem_rdy;
  logic        s_send, s_pop, s_bypass, s_push;
  logic [37:0] s_entry;
  logic        last_alu_fire, last_mem_fire;

  function automatic logic okRd(input logic [5:0] rd);
    return (rd != 6'd0) && (rd < 6'd32);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decide this cycle's winner from the priority list using only the model queue.
  task automatic planCycle();
    int n = mq.size();
    s_send = 1'b0; s_pop = 1'b0; s_bypass = 1'b0; s_entry = '0;
    if (n == DEPTH) begin
      s_send = 1'b1; s_pop = 1'b1; s_entry = mq[0];
    end else if (alu_valid) begin
      s_send = 1'b1; s_entry = {alu_rd, alu_data};
    end else if (n > 0) begin
      s_send = 1'b1; s_pop = 1'b1; s_entry = mq[0];
    end else if (mem_valid) begin
      s_send = 1'b1; s_bypass = 1'b1; s_entry = {mem_rd, mem_data};
    end
    m_alu_rdy = reset_n && (n != DEPTH);
    m_mem_rdy = reset_n && ((n != DEPTH) || s_pop);
    s_push    = mem_valid && m_mem_rdy && !s_bypass;
  endtask

  task automatic commitCycle();
    logic [5:0] rd;
    if (!reset_n) begin
      mq.delete();
      m_we = 1'b0; m_reg = '0; m_data = '0; m_pend = '0;
    end else begin
      if (m_we) m_pend[m_reg[4:0]] = 1'b0;
      if (issue_valid && okRd(issue_rd)) m_pend[issue_rd[4:0]] = 1'b1;
      if (s_pop) void'(mq.pop_front());
      if (s_push) mq.push_back({mem_rd, mem_data});
      rd   = s_entry[37:32];
      m_we = s_send && okRd(rd);
      if (m_we) begin
        m_reg  = rd;
        m_data = s_entry[31:0];
      end
    end
  endtask

  // One clock cycle: drive, check readys before the edge, check registered state after it.
  task automatic applyStimulus(input logic rst, input logic av, input logic [5:0] ard,
                               input logic [31:0] adat, input logic mv, input logic [5:0] mrd,
                               input logic [31:0] mdat, input logic iv, input logic [5:0] ird);
    reset_n = rst; alu_valid = av; alu_rd = ard; alu_data = adat;
    mem_valid = mv; mem_rd = mrd; mem_data = mdat; issue_valid = iv; issue_rd = ird;
    planCycle();
    #1;
    checkOutput("alu_ready", 64'(alu_ready), 64'(m_alu_rdy));
    checkOutput("mem_ready", 64'(mem_ready), 64'(m_mem_rdy));
    last_alu_fire = av && m_alu_rdy;
    last_mem_fire = mv && m_mem_rdy;
    @(posedge clk);
    #1;
    commitCycle();
    checkOutput("write_enable", 64'(write_enable), 64'(m_we));
    if (m_we) begin
      checkOutput("write_reg", 64'(write_reg), 64'(m_reg));
      checkOutput("write_data", 64'(write_data), 64'(m_data));
    end
    checkOutput("pending", 64'(pending), 64'(m_pend));
    checkOutput("fifo_count", 64'(fifo_count), 64'(mq.size()));
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0);
  endtask

  logic        r_av, r_mv, r_iv, r_rst;
  logic [5:0]  r_ard, r_mrd, r_ird;
  logic [31:0] r_adat, r_mdat;
  logic        hold_a, hold_m;

  initial begin
    reset_n = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
    alu_rd = '0; mem_rd = '0; issue_rd = '0; alu_data = '0; mem_data = '0;
    @(posedge clk);
    #1;

    // Reset for two cycles with traffic offered; readys must stay low throughout.
    applyStimulus(1'b0, 1'b1, 6'd4, 32'h1, 1'b1, 6'd6, 32'h2, 1'b1, 6'd8);
    applyStimulus(1'b0, 1'b1, 6'd4, 32'h1, 1'b1, 6'd6, 32'h2, 1'b1, 6'd8);
    checkOutput("rst_write_reg", 64'(write_reg), 64'd0);
    checkOutput("rst_write_data", 64'(write_data), 64'd0);
    idle();
    checkOutput("idle_alu_ready", 64'(alu_ready), 64'd1);
    checkOutput("idle_mem_ready", 64'(mem_ready), 64'd1);

    // Single ALU write with scoreboard set and clear.
    applyStimulus(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd5);
    checkOutput("pend5_set", 64'(pending[5]), 64'd1);
    applyStimulus(1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0);
    checkOutput("alu_we", 64'(write_enable), 64'd1);
    checkOutput("alu_reg", 64'(write_reg), 64'd5);
    checkOutput("alu_data", 64'(write_data), 64'hDEADBEEF);
    idle();
    checkOutput("pend5_clr", 64'(pending[5]), 64'd0);

    // Collision: ALU wins, memory result is buffered and written a cycle later.
    applyStimulus(1'b1, 1'b1, 6'd3, 32'h11, 1'b1, 6'd7, 32'h22, 1'b0, 6'd0);
    checkOutput("coll_reg1", 64'(write_reg), 64'd3);
    checkOutput("coll_cnt1", 64'(fifo_count), 64'd1);
    idle();
    checkOutput("coll_reg2", 64'(write_reg), 64'd7);
    checkOutput("coll_data2", 64'(write_data), 64'h22);
    checkOutput("coll_cnt2", 64'(fifo_count), 64'd0);

    // Fill and backpressure: third memory result arrives while the FIFO is full.
    applyStimulus(1'b1, 1'b1, 6'd10, 32'hA0, 1'b1, 6'd11, 32'hB1, 1'b0, 6'd0);
    applyStimulus(1'b1, 1'b1, 6'd12, 32'hA1, 1'b1, 6'd13, 32'hB2, 1'b0, 6'd0);
    checkOutput("fill_cnt", 64'(fifo_count), 64'd2);
    applyStimulus(1'b1, 1'b1, 6'd14, 32'hA2, 1'b1, 6'd15, 32'hB3, 1'b0, 6'd0);
    checkOutput("full_alu_blocked", 64'(last_alu_fire), 64'd0);
    checkOutput("full_mem_taken", 64'(last_mem_fire), 64'd1);
    checkOutput("full_head_reg", 64'(write_reg), 64'd11);
    applyStimulus(1'b1, 1'b1, 6'd14, 32'hA2, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0);
    checkOutput("drain_reg", 64'(write_reg), 64'd13);
    applyStimulus(1'b1, 1'b1, 6'd14, 32'hA2, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0);
    checkOutput("alu_after_drain", 64'(write_reg), 64'd14);
    idle();
    checkOutput("last_mem_reg", 64'(write_reg), 64'd15);
    checkOutput("last_mem_data", 64'(write_data), 64'hB3);

    // x0 and out-of-range destinations are consumed without a write.
    applyStimulus(1'b1, 1'b1, 6'd0, 32'h55, 1'b0, 6'd0, 32'd0, 1'b1, 6'd0);
    checkOutput("x0_we", 64'(write_enable), 64'd0);
    applyStimulus(1'b1, 1'b1, 6'd40, 32'h66, 1'b0, 6'd0, 32'd0, 1'b1, 6'd40);
    checkOutput("oor_we", 64'(write_enable), 64'd0);
    checkOutput("oor_pending", 64'(pending), 64'd0);

    // Set/clear race on r9: the new issue keeps the bit set.
    applyStimulus(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd9);
    applyStimulus(1'b1, 1'b1, 6'd9, 32'h99, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0);
    applyStimulus(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd9);
    checkOutput("race_pend9", 64'(pending[9]), 64'd1);
    idle();
    checkOutput("race_pend9_hold", 64'(pending[9]), 64'd1);

    // Reset while the FIFO is full discards everything.
    applyStimulus(1'b1, 1'b1, 6'd1, 32'h1, 1'b1, 6'd2, 32'h2, 1'b0, 6'd0);
    applyStimulus(1'b1, 1'b1, 6'd1, 32'h3, 1'b1, 6'd2, 32'h4, 1'b0, 6'd0);
    checkOutput("pre_rst_cnt", 64'(fifo_count), 64'd2);
    applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0);
    checkOutput("mid_rst_cnt", 64'(fifo_count), 64'd0);
    checkOutput("mid_rst_we", 64'(write_enable), 64'd0);
    idle();

    // Random traffic; sources hold their payload while stalled.
    hold_a = 1'b0; hold_m = 1'b0;
    r_av = 1'b0; r_mv = 1'b0; r_ard = '0; r_mrd = '0; r_adat = '0; r_mdat = '0;
    for (int i = 0; i < 500; i++) begin
      if (!hold_a) begin
        r_av   = ($urandom_range(0, 99) < 55);
        r_ard  = 6'($urandom_range(0, 39));
        r_adat = $urandom;
      end
      if (!hold_m) begin
        r_mv   = ($urandom_range(0, 99) < 60);
        r_mrd  = 6'($urandom_range(0, 39));
        r_mdat = $urandom;
      end
      r_iv  = ($urandom_range(0, 99) < 50);
      r_ird = 6'($urandom_range(0, 39));
      r_rst = ($urandom_range(0, 199) != 0);
      applyStimulus(r_rst, r_av, r_ard, r_adat, r_mv, r_mrd, r_mdat, r_iv, r_ird);
      hold_a = r_av && !last_alu_fire && r_rst;
      hold_m = r_mv && !last_mem_fire && r_rst;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writer side of the register file: merges results from the ALU and the memory/multicycle unit onto the single regfile write port (write_enable/write_reg/write_data).
- Buffers memory-side results in a small FIFO.
- Keeps a per-register pending scoreboard that decode uses for RAW stalls.
- Sits between execute/memory stages and the regfile.

Parameters:
- DATA_W, 32, result/register data width
- REG_ADDR_W, 6, register address width (matches regfile write_reg)
- NUM_REGS, 32, architectural registers tracked by the scoreboard
- FIFO_DEPTH, 2, memory-result buffer entries (power of two, >=2)

Ports:
- clk  input  1  clock, all state updates on posedge
- reset_n  input  1  synchronous active-low reset
- alu_valid  input  1  ALU result present
- alu_ready  output  1  unit accepts ALU result this cycle
- alu_rd  input  REG_ADDR_W  ALU destination
- alu_data  input  DATA_W  ALU result
- mem_valid  input  1  memory result present
- mem_ready  output  1  unit accepts memory result this cycle
- mem_rd  input  REG_ADDR_W  memory destination
- mem_data  input  DATA_W  memory result
- issue_valid  input  1  instruction issued with destination
- issue_rd  input  REG_ADDR_W  issued destination
- pending  output  NUM_REGS  bit r = write to register r in flight
- fifo_count  output  $clog2(FIFO_DEPTH)+1  buffered memory entries
- write_enable  output  1  regfile write strobe (registered)
- write_reg  output  REG_ADDR_W  regfile destination (registered)
- write_data  output  DATA_W  regfile data (registered)

Behaviour:
- Reset (reset_n=0 at posedge): write_enable=0, write_reg=0, write_data=0, pending=0, FIFO empty, fifo_count=0. alu_ready and mem_ready are forced to 0 while reset_n=0. Reset mid-operation discards FIFO contents and any in-flight output.
- Handshake: a transfer occurs on valid&&ready at posedge. Source data must stay stable while valid&&!ready.
- Output register selection each cycle, in priority order:
  - (1) FIFO full: FIFO head is sent; alu_ready=0.
  - (2) alu_valid: ALU result is sent; alu_ready=1.
  - (3) FIFO non-empty: FIFO head is sent.
  - (4) FIFO empty and mem_valid: memory result bypasses straight to the output register.
  - (5) none: write_enable<=0.
- alu_ready = reset_n && (fifo_count != FIFO_DEPTH).
- mem_ready = reset_n && (fifo_count != FIFO_DEPTH || FIFO head sent this cycle). A full FIFO that pops accepts a push in the same cycle.
- An accepted memory result not bypassed under rule (4) is pushed to the FIFO tail.
- A push and pop in the same cycle leave fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Latency:
  - Accepted ALU result, or bypassed memory result: write_enable high on the next cycle.
  - Buffered memory result: at least 2 cycles.
- Ordering: memory results are written in acceptance order. No ordering is guaranteed between ALU and memory results.
- Invalid destinations: rd==0 or rd>=NUM_REGS (rd[5]=1) is consumed normally but produces write_enable=0 and no scoreboard effect.
- Scoreboard set: issue_valid && issue_rd valid (nonzero, <NUM_REGS) sets pending[issue_rd].
- Scoreboard clear: write_enable=1 at a posedge clears pending[write_reg], on the same edge the regfile captures the write.
- Set and clear of the same register in one cycle: set wins.
- pending[0] is constantly 0.
- Outputs write_*, pending and fifo_count come directly from flops. Only alu_ready and mem_ready are combinational.

Decomposition:
- Package wb_pkg holds:
  - wb_entry_t packed struct {rd[REG_ADDR_W], data[DATA_W]}.
  - Constants REG_ADDR_W, DATA_W, NUM_REGS and ZERO_REG=0.
  - Helper function rd_valid(rd).
- One sub-module, wb_fifo: parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty/count and the same clk/reset_n.
- Arbitration and the scoreboard stay in writeback_unit.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, then 1 -> write_enable=0, pending=0, fifo_count=0, alu_ready=mem_ready=1; during reset both readys=0.
- ALU single write: issue_rd=5, then alu_valid, alu_rd=5, alu_data=0xDEADBEEF -> next cycle write_enable=1, write_reg=5, write_data=0xDEADBEEF; pending[5] rises after issue and clears after the write edge.
- Collision: alu (rd=3, 0x11) and mem (rd=7, 0x22) valid in the same cycle -> cycle+1 writes r3; cycle+2 writes r7 from the FIFO; fifo_count goes 0→1→0.
- Fill/backpressure: alu_valid every cycle plus 3 mem results -> FIFO reaches 2; next cycle alu_ready=0 and the FIFO head is written; mem_ready=1 on that cycle (pop+push); no result lost or reordered among memory results.
- x0 and out-of-range: alu_rd=0 and alu_rd=40 with valid data -> accepted (ready=1), write_enable stays 0, pending unchanged.
- Set/clear race: pending[9]=1 with a write to r9 on the output; issue_rd=9 in the same cycle -> pending[9] remains 1 after the edge. Assert reset_n=0 with fifo_count=2 -> FIFO empties, write_enable=0 next cycle.
